// File: rtl/wb_master_seq.sv
// Scripted Wishbone master: replays a loaded list of register/FIFO/exec accesses,
// holding each until ack, error or timeout, and waiting on SD core completion after exec writes.
module wb_master_seq #(
    parameter int DATA_W        = 128,
    parameter int ADR_W         = 5,
    parameter int DEPTH         = 16,
    parameter int TIMEOUT       = 255,
    parameter int CMD_EXEC_ADR  = 16,
    parameter int DATA_EXEC_ADR = 19
) (
    input  logic                     wb_clock,
    input  logic                     reset,
    input  logic                     ld_en,
    input  logic                     ld_clr,
    input  logic                     ld_we,
    input  logic [ADR_W-1:0]         ld_adr,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     start,
    input  logic                     ack_i,
    input  logic                     error_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    input  logic                     cmd_done_i,
    input  logic                     data_done_i,
    output logic                     strobe_o,
    output logic                     we_o,
    output logic [ADR_W-1:0]         adr_o,
    output logic [DATA_W-1:0]        wb_data_o,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [$clog2(DEPTH)-1:0] err_idx,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TMR_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [ADR_W-1:0] CMD_ADR   = ADR_W'(CMD_EXEC_ADR);
    localparam logic [ADR_W-1:0] DATA_ADR  = ADR_W'(DATA_EXEC_ADR);
    localparam logic [IDX_W:0]   DEPTH_CNT = (IDX_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        BUS,
        WAIT_CMD,
        WAIT_DATA,
        GAP,
        ABORT
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]  ptr, ptr_next;
    logic [TMR_W-1:0]  timer;
    logic              timer_run;
    logic              done_next;
    logic              rd_hit;
    logic              start_run;
    logic [1:0]        abort_code;
    logic              load_wr;
    logic [IDX_W:0]    count_next;

    logic              script_we   [DEPTH];
    logic [ADR_W-1:0]  script_adr  [DEPTH];
    logic [DATA_W-1:0] script_data [DEPTH];

    logic              cur_we;
    logic [ADR_W-1:0]  cur_adr;
    logic              timer_expired;
    logic              last_entry;

    assign cur_we        = script_we[ptr];
    assign cur_adr       = script_adr[ptr];
    assign timer_expired = (timer == TMR_LAST);
    assign last_entry    = ({1'b0, ptr} == count - (IDX_W + 1)'(1));

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        timer_run  = 1'b0;
        done_next  = 1'b0;
        rd_hit     = 1'b0;
        start_run  = 1'b0;
        abort_code = 2'd0;
        load_wr    = 1'b0;
        count_next = count;

        // Script editing is only honoured while idle; clear has priority over append.
        if (state == IDLE) begin
            if (ld_clr) begin
                count_next = '0;
            end else if (ld_en && !full) begin
                load_wr    = 1'b1;
                count_next = count + (IDX_W + 1)'(1);
            end
        end

        case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_next = BUS;
                        ptr_next   = '0;
                        start_run  = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            BUS: begin
                timer_run = 1'b1;
                if (error_i) begin
                    state_next = ABORT;
                    abort_code = 2'd1;
                end else if (ack_i) begin
                    if (!cur_we) begin
                        rd_hit     = 1'b1;
                        state_next = GAP;
                    end else if (cur_adr == CMD_ADR) begin
                        state_next = WAIT_CMD;
                    end else if (cur_adr == DATA_ADR) begin
                        state_next = WAIT_DATA;
                    end else begin
                        state_next = GAP;
                    end
                end else if (timer_expired) begin
                    state_next = ABORT;
                    abort_code = 2'd2;
                end
            end
            WAIT_CMD: begin
                timer_run = 1'b1;
                if (cmd_done_i) begin
                    state_next = GAP;
                end else if (timer_expired) begin
                    state_next = ABORT;
                    abort_code = 2'd3;
                end
            end
            WAIT_DATA: begin
                timer_run = 1'b1;
                if (data_done_i) begin
                    state_next = GAP;
                end else if (timer_expired) begin
                    state_next = ABORT;
                    abort_code = 2'd3;
                end
            end
            GAP: begin
                if (last_entry) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    ptr_next   = ptr + IDX_W'(1);
                    state_next = BUS;
                end
            end
            ABORT: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The timer restarts on every state change so each wait gets its full budget.
    always_ff @(posedge wb_clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            timer <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            if (state_next != state) begin
                timer <= '0;
            end else if (timer_run) begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge wb_clock) begin
        if (load_wr) begin
            script_we[count[IDX_W-1:0]]   <= ld_we;
            script_adr[count[IDX_W-1:0]]  <= ld_adr;
            script_data[count[IDX_W-1:0]] <= ld_data;
        end
    end

    // Outputs are registered from next-state decisions so bus signals switch right on the edge.
    always_ff @(posedge wb_clock or negedge reset) begin
        if (!reset) begin
            strobe_o  <= 1'b0;
            we_o      <= 1'b0;
            adr_o     <= '0;
            wb_data_o <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            err_idx   <= '0;
            count     <= '0;
            full      <= 1'b0;
        end else begin
            strobe_o <= (state_next == BUS);
            busy     <= (state_next != IDLE);
            done     <= done_next;
            rd_valid <= rd_hit;
            count    <= count_next;
            full     <= (count_next == DEPTH_CNT);
            if (rd_hit) begin
                rd_data <= wb_data_i;
            end
            if (state_next == BUS) begin
                we_o      <= script_we[ptr_next];
                adr_o     <= script_adr[ptr_next];
                wb_data_o <= script_data[ptr_next];
            end
            if (start_run) begin
                err      <= 1'b0;
                err_code <= 2'd0;
            end else if (abort_code != 2'd0) begin
                err      <= 1'b1;
                err_code <= abort_code;
                err_idx  <= ptr;
            end
        end
    end

endmodule
